// File: rtl/qspi_arb_pkg.sv
// Shared types for the QSPI request arbiter.
// State encoding and owner codes used by the arbiter and its bench.
package qspi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XIP_START,
    S_XIP_RUN,
    S_IND_START,
    S_IND_RUN,
    S_DRAIN
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_XIP  = 2'b01;
  localparam logic [1:0] OWNER_IND  = 2'b10;

endpackage

// File: rtl/qspi_arb_timeout_cnt.sv
// Cycle counter that flags expiry on the LIMIT-th enabled cycle.
// Shared by the start-acceptance and drain waits.
module qspi_arb_timeout_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // cnt_q holds the number of completed cycles, so the current
  // cycle is the (cnt_q+1)-th one.
  assign expired = enable && (cnt_q >= limit - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_req_arbiter.sv
// Arbitrates the QSPI sequencer between XIP reads and indirect mode.
// Bounded XIP priority, optional XIP preemption, start/drain timeouts.
module qspi_req_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int MAX_XIP_STREAK = 4,
  parameter int START_TIMEOUT  = 64,
  parameter int PREEMPT_EN     = 1
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       xip_req_in,
  input  logic       ind_req_in,
  input  logic       qspi_busy_in,
  input  logic       set_done_flag_in,
  output logic       xip_ack_out,
  output logic       ind_ack_out,
  output logic       ind_done_out,
  output logic       start_new_xip_seq_out,
  output logic       start_indrct_mode_out,
  output logic       break_seq_out,
  output logic [1:0] owner_out,
  output logic       start_err_out
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int SW = $clog2(MAX_XIP_STREAK + 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(START_TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_XIP_STREAK);

  arb_state_t    state_q;
  logic [SW-1:0] streak_q;
  logic          done_seen_q;
  logic          cnt_en;
  logic          expired;
  logic          ind_win;
  logic          streak_full;
  logic          xip_ack_set;
  logic          ind_ack_set;
  logic          preempt;

  // Timer only runs in waiting states; every other state holds it clear,
  // so it restarts from zero whenever a waiting state is entered.
  assign cnt_en = (state_q == S_XIP_START) ||
                  (state_q == S_IND_START) ||
                  (state_q == S_DRAIN);

  qspi_arb_timeout_cnt #(.W(TW)) u_tmr (
    .clk     (h_clk),
    .rst     (h_rst),
    .clear   (!cnt_en),
    .enable  (cnt_en),
    .limit   (TO_LIMIT),
    .expired (expired)
  );

  assign streak_full = (streak_q >= STREAK_MAX);
  assign ind_win     = ind_req_in && (!xip_req_in || streak_full);
  assign xip_ack_set = (state_q == S_XIP_START) && qspi_busy_in;
  assign ind_ack_set = (state_q == S_IND_START) && qspi_busy_in;
  assign preempt     = (PREEMPT_EN != 0) && ind_req_in && streak_full;

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      streak_q <= '0;
    end else if (!ind_req_in || ind_ack_set) begin
      streak_q <= '0;
    end else if (xip_ack_set && !streak_full) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q               <= S_IDLE;
      done_seen_q           <= 1'b0;
      xip_ack_out           <= 1'b0;
      ind_ack_out           <= 1'b0;
      ind_done_out          <= 1'b0;
      start_new_xip_seq_out <= 1'b0;
      start_indrct_mode_out <= 1'b0;
      break_seq_out         <= 1'b0;
      owner_out             <= OWNER_NONE;
      start_err_out         <= 1'b0;
    end else begin
      xip_ack_out   <= 1'b0;
      ind_ack_out   <= 1'b0;
      ind_done_out  <= 1'b0;
      start_err_out <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!qspi_busy_in) begin
            if (ind_win) begin
              state_q               <= S_IND_START;
              start_indrct_mode_out <= 1'b1;
              owner_out             <= OWNER_IND;
              done_seen_q           <= 1'b0;
            end else if (xip_req_in) begin
              state_q               <= S_XIP_START;
              start_new_xip_seq_out <= 1'b1;
              owner_out             <= OWNER_XIP;
            end
          end
        end
        S_XIP_START: begin
          if (qspi_busy_in) begin
            state_q               <= S_XIP_RUN;
            start_new_xip_seq_out <= 1'b0;
            xip_ack_out           <= 1'b1;
          end else if (expired) begin
            state_q               <= S_IDLE;
            start_new_xip_seq_out <= 1'b0;
            start_err_out         <= 1'b1;
            owner_out             <= OWNER_NONE;
          end
        end
        S_XIP_RUN: begin
          if (!qspi_busy_in) begin
            state_q       <= S_IDLE;
            break_seq_out <= 1'b0;
            owner_out     <= OWNER_NONE;
          end else begin
            break_seq_out <= break_seq_out || preempt;
          end
        end
        S_IND_START: begin
          if (qspi_busy_in) begin
            state_q               <= S_IND_RUN;
            start_indrct_mode_out <= 1'b0;
            ind_ack_out           <= 1'b1;
          end else if (expired) begin
            state_q               <= S_IDLE;
            start_indrct_mode_out <= 1'b0;
            start_err_out         <= 1'b1;
            owner_out             <= OWNER_NONE;
          end
        end
        S_IND_RUN: begin
          if (set_done_flag_in) begin
            done_seen_q <= 1'b1;
          end
          if (!qspi_busy_in) begin
            if (done_seen_q || set_done_flag_in) begin
              state_q      <= S_IDLE;
              ind_done_out <= 1'b1;
              owner_out    <= OWNER_NONE;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (set_done_flag_in) begin
            state_q      <= S_IDLE;
            ind_done_out <= 1'b1;
            owner_out    <= OWNER_NONE;
          end else if (expired) begin
            state_q       <= S_IDLE;
            start_err_out <= 1'b1;
            owner_out     <= OWNER_NONE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          owner_out <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_req_arbiter.sv
// Directed bench for qspi_req_arbiter: arbitration, starvation,
// preemption, start/drain timeouts and asynchronous reset.
module tb_qspi_req_arbiter;

  logic       h_clk = 1'b0;
  logic       h_rst = 1'b1;
  logic       xip_req_in = 1'b0;
  logic       ind_req_in = 1'b0;
  logic       qspi_busy_in = 1'b0;
  logic       set_done_flag_in = 1'b0;
  logic       xip_ack_out;
  logic       ind_ack_out;
  logic       ind_done_out;
  logic       start_new_xip_seq_out;
  logic       start_indrct_mode_out;
  logic       break_seq_out;
  logic [1:0] owner_out;
  logic       start_err_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 h_clk = ~h_clk;

  qspi_req_arbiter #(
    .MAX_XIP_STREAK (4),
    .START_TIMEOUT  (64),
    .PREEMPT_EN     (1)
  ) dut (
    .h_clk                 (h_clk),
    .h_rst                 (h_rst),
    .xip_req_in            (xip_req_in),
    .ind_req_in            (ind_req_in),
    .qspi_busy_in          (qspi_busy_in),
    .set_done_flag_in      (set_done_flag_in),
    .xip_ack_out           (xip_ack_out),
    .ind_ack_out           (ind_ack_out),
    .ind_done_out          (ind_done_out),
    .start_new_xip_seq_out (start_new_xip_seq_out),
    .start_indrct_mode_out (start_indrct_mode_out),
    .break_seq_out         (break_seq_out),
    .owner_out             (owner_out),
    .start_err_out         (start_err_out)
  );

  function automatic logic [8:0] outs();
    return {xip_ack_out, ind_ack_out, ind_done_out,
            start_new_xip_seq_out, start_indrct_mode_out,
            break_seq_out, owner_out, start_err_out};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge h_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    h_rst = 1'b1;
    tick(2);
    n_chk++;
    if (outs() !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want %b", outs(), 9'b0);
    end
    h_rst = 1'b0;
    tick(2);
    n_chk++;
    if (outs() !== 9'b0) begin
      n_fail++;
      $display("FAIL idle_outs: got %b want %b", outs(), 9'b0);
    end
  endtask

  task automatic test_xip_only();
    int hi;
    hi = 0;
    xip_req_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (start_new_xip_seq_out === 1'b1 && xip_ack_out === 1'b0 &&
          owner_out === 2'b01)
        hi++;
      if (c == 4) qspi_busy_in = 1'b1;
    end
    n_chk++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL xip_start_cycles: got %0d want %0d", hi, 4);
    end
    tick();
    n_chk++;
    if ({xip_ack_out, start_new_xip_seq_out, owner_out} !== 4'b1001) begin
      n_fail++;
      $display("FAIL xip_ack: got %b want %b",
               {xip_ack_out, start_new_xip_seq_out, owner_out}, 4'b1001);
    end
    xip_req_in = 1'b0;
    tick(20);
    n_chk++;
    if ({xip_ack_out, owner_out} !== 3'b001) begin
      n_fail++;
      $display("FAIL xip_run: got %b want %b",
               {xip_ack_out, owner_out}, 3'b001);
    end
    qspi_busy_in = 1'b0;
    tick();
    n_chk++;
    if (owner_out !== 2'b00) begin
      n_fail++;
      $display("FAIL xip_release: got %b want %b", owner_out, 2'b00);
    end
  endtask

  task automatic test_both();
    int dones;
    dones = 0;
    xip_req_in = 1'b1;
    ind_req_in = 1'b1;
    tick();
    n_chk++;
    if ({start_new_xip_seq_out, start_indrct_mode_out, owner_out}
        !== 4'b1001) begin
      n_fail++;
      $display("FAIL both_first: got %b want %b",
               {start_new_xip_seq_out, start_indrct_mode_out, owner_out},
               4'b1001);
    end
    qspi_busy_in = 1'b1;
    tick();
    xip_req_in = 1'b0;
    n_chk++;
    if ({xip_ack_out, ind_ack_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_xip_ack: got %b want %b",
               {xip_ack_out, ind_ack_out}, 2'b10);
    end
    tick(3);
    qspi_busy_in = 1'b0;
    tick(2);
    n_chk++;
    if ({start_indrct_mode_out, owner_out} !== 3'b110) begin
      n_fail++;
      $display("FAIL both_ind_start: got %b want %b",
               {start_indrct_mode_out, owner_out}, 3'b110);
    end
    qspi_busy_in = 1'b1;
    tick();
    ind_req_in = 1'b0;
    n_chk++;
    if ({ind_ack_out, start_indrct_mode_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_ind_ack: got %b want %b",
               {ind_ack_out, start_indrct_mode_out}, 2'b10);
    end
    set_done_flag_in = 1'b1;
    tick();
    set_done_flag_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 2) qspi_busy_in = 1'b0;
      if (ind_done_out === 1'b1) dones++;
    end
    n_chk++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL both_done_pulses: got %0d want %0d", dones, 1);
    end
  endtask

  task automatic test_starvation();
    int acks;
    acks = 0;
    xip_req_in = 1'b1;
    ind_req_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      qspi_busy_in = 1'b1;
      tick();
      if (xip_ack_out === 1'b1) acks++;
      tick(2);
      n_chk++;
      if (break_seq_out !== (k == 4)) begin
        n_fail++;
        $display("FAIL starve_break_%0d: got %b want %b",
                 k, break_seq_out, (k == 4));
      end
      qspi_busy_in = 1'b0;
      tick();
      n_chk++;
      if ({break_seq_out, owner_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL starve_release_%0d: got %b want %b",
                 k, {break_seq_out, owner_out}, 3'b000);
      end
    end
    n_chk++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL starve_xip_acks: got %0d want %0d", acks, 4);
    end
    tick();
    n_chk++;
    if ({start_new_xip_seq_out, start_indrct_mode_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL starve_ind_grant: got %b want %b",
               {start_new_xip_seq_out, start_indrct_mode_out}, 2'b01);
    end
    qspi_busy_in = 1'b1;
    tick();
    ind_req_in = 1'b0;
    set_done_flag_in = 1'b1;
    tick();
    set_done_flag_in = 1'b0;
    qspi_busy_in = 1'b0;
    tick();
    n_chk++;
    if (ind_done_out !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_ind_done: got %b want %b", ind_done_out, 1'b1);
    end
    tick();
    n_chk++;
    if ({start_new_xip_seq_out, owner_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL starve_fifth_xip: got %b want %b",
               {start_new_xip_seq_out, owner_out}, 3'b101);
    end
    qspi_busy_in = 1'b1;
    tick();
    xip_req_in = 1'b0;
    qspi_busy_in = 1'b0;
    tick(2);
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    xip_req_in = 1'b1;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (start_new_xip_seq_out === 1'b1 && start_err_out === 1'b0) hi++;
    end
    n_chk++;
    if (hi !== 64) begin
      n_fail++;
      $display("FAIL to_start_cycles: got %0d want %0d", hi, 64);
    end
    tick();
    n_chk++;
    if ({start_err_out, start_new_xip_seq_out, xip_ack_out, owner_out}
        !== 5'b10000) begin
      n_fail++;
      $display("FAIL to_err: got %b want %b",
               {start_err_out, start_new_xip_seq_out, xip_ack_out,
                owner_out}, 5'b10000);
    end
    tick();
    n_chk++;
    if ({start_err_out, start_new_xip_seq_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_rearb: got %b want %b",
               {start_err_out, start_new_xip_seq_out}, 2'b01);
    end
    qspi_busy_in = 1'b1;
    tick();
    xip_req_in = 1'b0;
    qspi_busy_in = 1'b0;
    tick(2);
  endtask

  task automatic test_drain();
    for (int pass = 0; pass < 2; pass++) begin
      ind_req_in = 1'b1;
      tick();
      qspi_busy_in = 1'b1;
      tick();
      ind_req_in = 1'b0;
      tick(2);
      qspi_busy_in = 1'b0;
      tick();
      n_chk++;
      if ({ind_done_out, start_err_out, owner_out} !== 4'b0010) begin
        n_fail++;
        $display("FAIL drain_enter_%0d: got %b want %b", pass,
                 {ind_done_out, start_err_out, owner_out}, 4'b0010);
      end
      if (pass == 0) begin
        tick(2);
        set_done_flag_in = 1'b1;
        tick();
        set_done_flag_in = 1'b0;
        n_chk++;
        if ({ind_done_out, owner_out} !== 3'b100) begin
          n_fail++;
          $display("FAIL drain_done: got %b want %b",
                   {ind_done_out, owner_out}, 3'b100);
        end
      end else begin
        tick(63);
        n_chk++;
        if ({start_err_out, owner_out} !== 3'b010) begin
          n_fail++;
          $display("FAIL drain_wait: got %b want %b",
                   {start_err_out, owner_out}, 3'b010);
        end
        tick();
        n_chk++;
        if ({start_err_out, ind_done_out, owner_out} !== 4'b1000) begin
          n_fail++;
          $display("FAIL drain_timeout: got %b want %b",
                   {start_err_out, ind_done_out, owner_out}, 4'b1000);
        end
      end
      tick(2);
    end
  endtask

  task automatic test_reset_mid();
    xip_req_in = 1'b1;
    ind_req_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      qspi_busy_in = 1'b1;
      tick(3);
      if (k < 4) begin
        qspi_busy_in = 1'b0;
        tick();
      end
    end
    n_chk++;
    if (break_seq_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_break: got %b want %b", break_seq_out, 1'b1);
    end
    #2;
    h_rst = 1'b1;
    #1;
    n_chk++;
    if (outs() !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_async: got %b want %b", outs(), 9'b0);
    end
    qspi_busy_in = 1'b0;
    tick(2);
    h_rst = 1'b0;
    tick();
    n_chk++;
    if ({start_new_xip_seq_out, start_indrct_mode_out, owner_out}
        !== 4'b1001) begin
      n_fail++;
      $display("FAIL rst_streak_clear: got %b want %b",
               {start_new_xip_seq_out, start_indrct_mode_out, owner_out},
               4'b1001);
    end
    qspi_busy_in = 1'b1;
    tick();
    xip_req_in = 1'b0;
    ind_req_in = 1'b0;
    qspi_busy_in = 1'b0;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_xip_only();
    test_both();
    test_starvation();
    test_timeout();
    test_drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
